axi_to_mem_bridge: RTL

AXI_TO_MEM_BRIDGE -- requirements
Module: axi_to_mem_bridge

---
 rtl/axi_to_mem_bridge.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/axi_to_mem_bridge.sv
// AXI4 slave to single-word MEM request/response bridge.
// Bursts become sequential MEM accesses, with one AXI transaction in flight at a time.
module axi_to_mem_bridge #(
    parameter int unsigned LOCAL_DATA_WIDTH = 32,
    parameter int unsigned LOCAL_ADDR_WIDTH = 32,
    parameter int unsigned LOCAL_ID_WIDTH   = 2
) (
    input  logic                          clock_i,
    input  logic                          reset_i,
    input  logic [LOCAL_ID_WIDTH-1:0]     s_axi_awid_i,
    input  logic [LOCAL_ADDR_WIDTH-1:0]   s_axi_awaddr_i,
    input  logic [7:0]                    s_axi_awlen_i,
    input  logic [2:0]                    s_axi_awsize_i,
    input  logic [1:0]                    s_axi_awburst_i,
    input  logic                          s_axi_awvalid_i,
    output logic                          s_axi_awready_o,
    input  logic [LOCAL_DATA_WIDTH-1:0]   s_axi_wdata_i,
    input  logic [LOCAL_DATA_WIDTH/8-1:0] s_axi_wstrb_i,
    input  logic                          s_axi_wlast_i,
    input  logic                          s_axi_wvalid_i,
    output logic                          s_axi_wready_o,
    output logic [LOCAL_ID_WIDTH-1:0]     s_axi_bid_o,
    output logic [1:0]                    s_axi_bresp_o,
    output logic                          s_axi_bvalid_o,
    input  logic                          s_axi_bready_i,
    input  logic [LOCAL_ID_WIDTH-1:0]     s_axi_arid_i,
    input  logic [LOCAL_ADDR_WIDTH-1:0]   s_axi_araddr_i,
    input  logic [7:0]                    s_axi_arlen_i,
    input  logic [2:0]                    s_axi_arsize_i,
    input  logic [1:0]                    s_axi_arburst_i,
    input  logic                          s_axi_arvalid_i,
    output logic                          s_axi_arready_o,
    output logic [LOCAL_ID_WIDTH-1:0]     s_axi_rid_o,
    output logic [LOCAL_DATA_WIDTH-1:0]   s_axi_rdata_o,
    output logic [1:0]                    s_axi_rresp_o,
    output logic                          s_axi_rlast_o,
    output logic                          s_axi_rvalid_o,
    input  logic                          s_axi_rready_i,
    output logic                          mem_req_o,
    output logic                          mem_we_o,
    output logic [LOCAL_ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [LOCAL_DATA_WIDTH-1:0]   mem_wdata_o,
    output logic [LOCAL_DATA_WIDTH/8-1:0] mem_be_o,
    input  logic                          mem_gnt_i,
    input  logic                          mem_valid_i,
    input  logic [LOCAL_DATA_WIDTH-1:0]   mem_rdata_i,
    input  logic                          mem_error_i
);

    typedef enum logic [2:0] {
        StIdle, StWrBeat, StWrWait, StWrResp, StRdReq, StRdWait, StRdData
    } state_e;

    state_e                          state_q, state_d;
    logic [LOCAL_ID_WIDTH-1:0]       id_q;
    logic [LOCAL_ADDR_WIDTH-1:0]     addr_q, addr_nxt;
    logic [2:0]                      size_q;
    logic [1:0]                      burst_q;
    logic [8:0]                      beats_q;
    logic                            err_q, rerr_q, prefer_wr_q;
    logic                            mem_req_q, mem_we_q;
    logic [LOCAL_DATA_WIDTH-1:0]     wdata_q, rdata_q;
    logic [LOCAL_DATA_WIDTH/8-1:0]   be_q;
    logic                            aw_grant, ar_grant, last_beat, w_hs, wr_done;

    // Arbitration: on a tie the channel not granted last time wins.
    assign aw_grant  = (state_q == StIdle) && s_axi_awvalid_i && (!s_axi_arvalid_i || prefer_wr_q);
    assign ar_grant  = (state_q == StIdle) && s_axi_arvalid_i && (!s_axi_awvalid_i || !prefer_wr_q);
    assign last_beat = (beats_q == 9'd1);
    assign w_hs      = (state_q == StWrBeat) && s_axi_wvalid_i;
    assign wr_done   = (state_q == StWrWait) && !mem_req_q && mem_valid_i;
    // WRAP is handled as INCR; the sum wraps at the top of the address space.
    assign addr_nxt  = (burst_q == 2'b00) ? addr_q
                                          : addr_q + (LOCAL_ADDR_WIDTH'(1) << size_q);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (aw_grant) begin
                    state_d = StWrBeat;
                end else if (ar_grant) begin
                    state_d = StRdReq;
                end
            end
            StWrBeat: if (s_axi_wvalid_i) state_d = StWrWait;
            StWrWait: if (wr_done) state_d = last_beat ? StWrResp : StWrBeat;
            StWrResp: if (s_axi_bready_i) state_d = StIdle;
            StRdReq:  if (mem_gnt_i) state_d = StRdWait;
            StRdWait: if (mem_valid_i) state_d = StRdData;
            StRdData: if (s_axi_rready_i) state_d = last_beat ? StIdle : StRdReq;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        s_axi_awready_o = 1'b0;
        s_axi_arready_o = 1'b0;
        s_axi_wready_o  = 1'b0;
        s_axi_bvalid_o  = 1'b0;
        s_axi_rvalid_o  = 1'b0;
        s_axi_rlast_o   = 1'b0;
        unique case (state_q)
            StIdle: begin
                s_axi_awready_o = aw_grant;
                s_axi_arready_o = ar_grant;
            end
            StWrBeat: s_axi_wready_o = 1'b1;
            StWrResp: s_axi_bvalid_o = 1'b1;
            StRdData: begin
                s_axi_rvalid_o = 1'b1;
                s_axi_rlast_o  = last_beat;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            id_q        <= '0;
            addr_q      <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            beats_q     <= '0;
            err_q       <= 1'b0;
            rerr_q      <= 1'b0;
            prefer_wr_q <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            wdata_q     <= '0;
            be_q        <= '0;
            rdata_q     <= '0;
        end else begin
            if (aw_grant) begin
                id_q        <= s_axi_awid_i;
                addr_q      <= s_axi_awaddr_i;
                size_q      <= s_axi_awsize_i;
                burst_q     <= s_axi_awburst_i;
                beats_q     <= {1'b0, s_axi_awlen_i} + 9'd1;
                err_q       <= 1'b0;
                prefer_wr_q <= 1'b0;
            end else if (ar_grant) begin
                id_q        <= s_axi_arid_i;
                addr_q      <= s_axi_araddr_i;
                size_q      <= s_axi_arsize_i;
                burst_q     <= s_axi_arburst_i;
                beats_q     <= {1'b0, s_axi_arlen_i} + 9'd1;
                prefer_wr_q <= 1'b1;
                mem_req_q   <= 1'b1;
                mem_we_q    <= 1'b0;
                be_q        <= '1;
            end
            if (w_hs) begin
                mem_req_q <= 1'b1;
                mem_we_q  <= 1'b1;
                wdata_q   <= s_axi_wdata_i;
                be_q      <= s_axi_wstrb_i;
                if (s_axi_wlast_i != last_beat) err_q <= 1'b1;
            end
            if (mem_req_q && mem_gnt_i) mem_req_q <= 1'b0;
            if (wr_done) begin
                if (mem_error_i) err_q <= 1'b1;
                addr_q  <= addr_nxt;
                beats_q <= beats_q - 9'd1;
            end
            if ((state_q == StRdWait) && mem_valid_i) begin
                rdata_q <= mem_rdata_i;
                rerr_q  <= mem_error_i;
            end
            if ((state_q == StRdData) && s_axi_rready_i) begin
                addr_q  <= addr_nxt;
                beats_q <= beats_q - 9'd1;
                if (!last_beat) begin
                    mem_req_q <= 1'b1;
                    mem_we_q  <= 1'b0;
                    be_q      <= '1;
                end
            end
        end
    end

    assign s_axi_bid_o   = id_q;
    assign s_axi_bresp_o = err_q ? 2'b10 : 2'b00;
    assign s_axi_rid_o   = id_q;
    assign s_axi_rdata_o = rdata_q;
    assign s_axi_rresp_o = rerr_q ? 2'b10 : 2'b00;
    assign mem_req_o     = mem_req_q;
    assign mem_we_o      = mem_we_q;
    assign mem_addr_o    = addr_q;
    assign mem_wdata_o   = wdata_q;
    assign mem_be_o      = be_q;

endmodule
